// File: rtl/seq_player.sv
// Loadable pattern player: plays a DEPTH x CH word memory at a programmable step period, one-shot or looped.
// Optional macro SEQ_PLAYER_ERRINJ_EN adds live error-injection ports that corrupt one selected step.
module seq_player #(
    parameter int CH = 2,
    parameter int DEPTH = 32,
    parameter int DIV_W = 16,
    parameter logic [CH-1:0] IDLE_VAL = {CH{1'b0}},
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [CH-1:0]    wr_data,
    input  logic [AW:0]      len,
    input  logic [DIV_W-1:0] period,
    input  logic             loop,
    input  logic             start,
    input  logic             stop,
    output logic [CH-1:0]    out,
    output logic             step_strobe,
    output logic [AW-1:0]    idx,
    output logic             busy,
    output logic             done
`ifdef SEQ_PLAYER_ERRINJ_EN
    ,
    input  logic             err_en,
    input  logic [AW-1:0]    err_idx,
    input  logic [CH-1:0]    err_mask
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    localparam logic [AW:0]  DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [31:0]  DEPTH_U = 32'(DEPTH);

    logic [CH-1:0]    r_mem [DEPTH];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CH-1:0]    r_out;
    logic [CH-1:0]    w_out_nxt;
    logic [AW-1:0]    r_idx;
    logic [AW-1:0]    w_idx_nxt;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] r_per_m1;
    logic [DIV_W-1:0] w_per_m1_nxt;
    logic [AW-1:0]    r_last;
    logic [AW-1:0]    w_last_nxt;
    logic             r_loop;
    logic             w_loop_nxt;
    logic             r_strobe;
    logic             w_strobe_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic             w_wr_ok;
    logic [AW:0]      w_eff_len;
    logic [AW:0]      w_len_m1;
    logic [DIV_W-1:0] w_eff_per_m1;
    logic             w_start_ok;
    logic             w_last_hit;
    logic [AW-1:0]    w_fetch_idx;
    logic [CH-1:0]    w_fetch_dat;

    // Out-of-range write addresses (non power-of-two DEPTH) are dropped.
    assign w_wr_ok = wr_en && (32'(wr_addr) < DEPTH_U);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign w_eff_len    = (len > DEPTH_L) ? DEPTH_L : len;
    assign w_len_m1     = w_eff_len - (AW+1)'(1);
    assign w_eff_per_m1 = (period == '0) ? '0 : period - DIV_W'(1);
    assign w_start_ok   = start && !stop && (len != '0);
    assign w_last_hit   = (r_idx == r_last);

    // Every fetch is either index 0 (start or wrap) or the next index; a same-edge write is forwarded.
    assign w_fetch_idx = ((r_state == S_PLAY) && !w_last_hit) ? r_idx + AW'(1) : '0;
    assign w_fetch_dat = (w_wr_ok && (wr_addr == w_fetch_idx)) ? wr_data : r_mem[w_fetch_idx];

    always_comb begin
        w_state_nxt  = r_state;
        w_out_nxt    = r_out;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_per_m1_nxt = r_per_m1;
        w_last_nxt   = r_last;
        w_loop_nxt   = r_loop;
        w_strobe_nxt = 1'b0;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_out_nxt = IDLE_VAL;
                w_idx_nxt = '0;
                w_cnt_nxt = '0;
                if (w_start_ok) begin
                    w_state_nxt  = S_PLAY;
                    w_out_nxt    = w_fetch_dat;
                    w_strobe_nxt = 1'b1;
                    w_cnt_nxt    = w_eff_per_m1;
                    w_per_m1_nxt = w_eff_per_m1;
                    w_last_nxt   = w_len_m1[AW-1:0];
                    w_loop_nxt   = loop;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_out_nxt   = IDLE_VAL;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - DIV_W'(1);
                end else if (!w_last_hit || r_loop) begin
                    w_idx_nxt    = w_fetch_idx;
                    w_out_nxt    = w_fetch_dat;
                    w_strobe_nxt = 1'b1;
                    w_cnt_nxt    = r_per_m1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_out_nxt   = IDLE_VAL;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_out_nxt   = IDLE_VAL;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_out    <= IDLE_VAL;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_per_m1 <= '0;
            r_last   <= '0;
            r_loop   <= 1'b0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_out    <= w_out_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_per_m1 <= w_per_m1_nxt;
            r_last   <= w_last_nxt;
            r_loop   <= w_loop_nxt;
            r_strobe <= w_strobe_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign busy        = (r_state == S_PLAY);
    assign idx         = r_idx;
    assign step_strobe = r_strobe;
    assign done        = r_done;

`ifdef SEQ_PLAYER_ERRINJ_EN
    assign out = (busy && err_en && (r_idx == err_idx)) ? (r_out ^ err_mask) : r_out;
`else
    assign out = r_out;
`endif

endmodule
